// File: rtl/i2c_reg_if.sv
// i2c_reg_if: host-side register file and control stage for the I2C master core.
// Decodes a single-cycle host bus, holds ADR/FDR/CR/DR/DFSRR, merges the core's
// synchronised status into SR (sticky MIF/MAL) and strobes TXRX_DONE after DR access.
// Optional feature: define I2C_REG_IRQ_EN to drive O_IRQ = MIF & CR.MIEN (registered);
// otherwise O_IRQ is tied low while MIEN is still stored and readable.
module i2c_reg_if #(
    parameter logic [7:0] DFSRR_RST = 8'h10,
    parameter logic [7:0] FDR_RST   = 8'h00
) (
    input  logic       I_CLK,
    input  logic       I_RSTN,
    input  logic       I_BUS_SEL,
    input  logic       I_BUS_WR,
    input  logic [2:0] I_BUS_ADDR,
    input  logic [7:0] I_BUS_WDATA,
    output logic [7:0] O_BUS_RDATA,
    output logic       O_BUS_ACK,
    output logic [7:0] O_I2CADR,
    output logic [7:0] O_I2CFDR,
    output logic [7:0] O_I2CCR,
    output logic [7:0] O_I2CDR,
    output logic [7:0] O_I2CDFSRR,
    input  logic [7:0] I_I2CSR,
    output logic       O_TXRX_DONE,
    output logic       O_IRQ
);

    // Register indexes
    localparam logic [2:0] A_ADR   = 3'd0;
    localparam logic [2:0] A_FDR   = 3'd1;
    localparam logic [2:0] A_CR    = 3'd2;
    localparam logic [2:0] A_SR    = 3'd3;
    localparam logic [2:0] A_DR    = 3'd4;
    localparam logic [2:0] A_DFSRR = 3'd5;

    // CR bit positions
    localparam int unsigned CR_MEN  = 7;
    localparam int unsigned CR_MIEN = 6;
    localparam int unsigned CR_RSTA = 2;

    // Synchronised status: {MCF, MBB, MAL, RXAK}
    localparam int unsigned S_MCF  = 3;
    localparam int unsigned S_MBB  = 2;
    localparam int unsigned S_MAL  = 1;
    localparam int unsigned S_RXAK = 0;

    logic [7:0] adr_q,   adr_d;
    logic [7:0] fdr_q,   fdr_d;
    logic [7:0] cr_q,    cr_d;
    logic [7:0] dr_q,    dr_d;
    logic [7:0] dfsrr_q, dfsrr_d;
    logic       mif_q,   mif_d;
    logic       mal_q,   mal_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q,   ack_d;
    logic       done_q,  done_d;
    logic [1:0] pend_q,  pend_d;

    logic [3:0] sync1_q, sync2_q;
    logic       mcf_prev_q;

    logic       wr_en, rd_en;
    logic       mcf_rise;
    logic       men_fall;
    logic       dr_access;
    logic [7:0] sr_val;
    logic [7:0] rd_val;

    // Status bits the register interface never looks at
    logic       unused_sr_bits;
    assign unused_sr_bits = ^{I_I2CSR[6], I_I2CSR[3:1]};

    // Two-flop synchroniser on the status bits that feed SR, plus MCF edge history
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            mcf_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {I_I2CSR[7], I_I2CSR[5], I_I2CSR[4], I_I2CSR[0]};
            sync2_q    <= sync1_q;
            mcf_prev_q <= sync2_q[S_MCF];
        end
    end

    // Host-visible status and read-data mux
    always_comb begin
        sr_val = {sync2_q[S_MCF], 1'b0, sync2_q[S_MBB], mal_q,
                  2'b00, mif_q, sync2_q[S_RXAK]};
        rd_val = '0;
        unique case (I_BUS_ADDR)
            A_ADR:   rd_val = adr_q;
            A_FDR:   rd_val = fdr_q;
            A_CR:    rd_val = cr_q & 8'hFB;
            A_SR:    rd_val = sr_val;
            A_DR:    rd_val = dr_q;
            A_DFSRR: rd_val = dfsrr_q;
            default: rd_val = '0;
        endcase
    end

    // Next-state logic for registers, sticky flags and the TXRX_DONE scheduler
    always_comb begin
        adr_d   = adr_q;
        fdr_d   = fdr_q;
        cr_d    = cr_q;
        dr_d    = dr_q;
        dfsrr_d = dfsrr_q;
        mif_d   = mif_q;
        mal_d   = mal_q;
        rdata_d = rdata_q;
        ack_d   = I_BUS_SEL;
        pend_d  = pend_q;

        wr_en     = I_BUS_SEL &  I_BUS_WR;
        rd_en     = I_BUS_SEL & ~I_BUS_WR;
        mcf_rise  = sync2_q[S_MCF] & ~mcf_prev_q;
        men_fall  = wr_en && (I_BUS_ADDR == A_CR) && cr_q[CR_MEN] && !I_BUS_WDATA[CR_MEN];
        dr_access = I_BUS_SEL && (I_BUS_ADDR == A_DR) && cr_q[CR_MEN];

        // RSTA lives for one cycle only
        cr_d[CR_RSTA] = 1'b0;

        if (rd_en) begin
            rdata_d = rd_val;
        end

        if (wr_en) begin
            unique case (I_BUS_ADDR)
                A_ADR:   adr_d   = I_BUS_WDATA;
                A_FDR:   fdr_d   = I_BUS_WDATA;
                A_CR:    cr_d    = I_BUS_WDATA & 8'hFD;
                A_SR: begin
                    if (!I_BUS_WDATA[1]) mif_d = 1'b0;
                    if (!I_BUS_WDATA[4]) mal_d = 1'b0;
                end
                A_DR:    dr_d    = I_BUS_WDATA;
                A_DFSRR: dfsrr_d = I_BUS_WDATA;
                default: ;
            endcase
        end

        // Status events are applied after host clears so a same-cycle set wins
        if (mcf_rise)       mif_d = 1'b1;
        if (sync2_q[S_MAL]) mal_d = 1'b1;

        // Strobes are spaced by at least one low cycle; extra requests queue up
        done_d = (pend_q != 2'd0) && !done_q;
        unique case ({dr_access, done_d})
            2'b10:   if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
            2'b01:   pend_d = pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase

        // Disabling the core flushes flags and any queued strobe
        if (men_fall) begin
            mif_d  = 1'b0;
            mal_d  = 1'b0;
            pend_d = '0;
            done_d = 1'b0;
        end
    end

    // Register file, bus response and strobe state
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            adr_q   <= '0;
            fdr_q   <= FDR_RST;
            cr_q    <= '0;
            dr_q    <= '0;
            dfsrr_q <= DFSRR_RST;
            mif_q   <= 1'b0;
            mal_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            adr_q   <= adr_d;
            fdr_q   <= fdr_d;
            cr_q    <= cr_d;
            dr_q    <= dr_d;
            dfsrr_q <= dfsrr_d;
            mif_q   <= mif_d;
            mal_q   <= mal_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

`ifdef I2C_REG_IRQ_EN
    logic irq_q;

    // Interrupt request follows MIF gated by MIEN, one cycle later
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= mif_q & cr_q[CR_MIEN];
        end
    end

    assign O_IRQ = irq_q;
`else
    assign O_IRQ = 1'b0;
`endif

    assign O_BUS_RDATA = rdata_q;
    assign O_BUS_ACK   = ack_q;
    assign O_I2CADR    = adr_q;
    assign O_I2CFDR    = fdr_q;
    assign O_I2CCR     = cr_q;
    assign O_I2CDR     = dr_q;
    assign O_I2CDFSRR  = dfsrr_q;
    assign O_TXRX_DONE = done_q;

endmodule

// File: doc/i2c_reg_if.md
Name: i2c_reg_if

Overview:
- Host-side register file and control stage directly upstream of the I2C master core.
- Decodes a simple single-cycle host bus and holds the ADR/FDR/CR/DR/DFSRR registers that drive the core.
- Merges the core's live status into a host-visible SR with sticky MIF/MAL.
- Generates the TXRX_DONE strobe that re-arms the core after each byte, plus an interrupt request.

Parameters:
- DFSRR_RST, 8'h10, reset value of the digital-filter sampling-rate register.
- FDR_RST, 8'h00, reset value of the frequency-divider register.

Ports:
- I_CLK  input  1  system clock.
- I_RSTN  input  1  reset; asynchronous assert, active-low.
- I_BUS_SEL  input  1  access request, one cycle per access.
- I_BUS_WR  input  1  1 = write, 0 = read; qualified by I_BUS_SEL.
- I_BUS_ADDR  input  3  register index.
- I_BUS_WDATA  input  8  write data.
- O_BUS_RDATA  output  8  registered read data, valid with O_BUS_ACK.
- O_BUS_ACK  output  1  one-cycle acknowledge.
- O_I2CADR  output  8  slave address register to core.
- O_I2CFDR  output  8  frequency divider register to core.
- O_I2CCR  output  8  control register to core.
- O_I2CDR  output  8  data register to core.
- O_I2CDFSRR  output  8  sampling-rate register to core.
- I_I2CSR  input  8  raw status from core (bit7 MCF, bit5 MBB, bit4 MAL, bit0 RXAK).
- O_TXRX_DONE  output  1  one-cycle strobe re-arming the core.
- O_IRQ  output  1  interrupt request (see Optional Feature).

Behaviour:
- Clock and reset: one clock, I_CLK. Reset I_RSTN is asynchronous, active-low. All state is cleared on reset; deassertion is synchronous by design.
- Reset values:
  - ADR = 0x00; FDR = FDR_RST; CR = 0x00; DR = 0x00; DFSRR = DFSRR_RST.
  - MIF = 0; MAL_sticky = 0; O_BUS_RDATA = 0x00; O_BUS_ACK = 0; O_TXRX_DONE = 0; O_IRQ = 0.
  - Sync flops and the edge-detect history flop = 0.
- Register map: 0 ADR, 1 FDR, 2 CR, 3 SR, 4 DR, 5 DFSRR. Indexes 6 and 7 read 0x00, ignore writes and are still acknowledged.
- Bus timing:
  - I_BUS_SEL high in cycle N gives O_BUS_ACK high in cycle N+1, with read data valid in N+1.
  - A write updates the register at the N+1 clock edge.
  - Back-to-back requests are legal: ack each cycle, no wait states.
- CR:
  - bit7 MEN, bit6 MIEN, bit5 MSTA, bit4 MTX, bit3 TXAK, bit2 RSTA, bit0 BCST; bit1 is reserved and reads 0.
  - RSTA is self-clearing: it is high on O_I2CCR for exactly one cycle after the write, and always reads 0.
- Status sync:
  - I_I2CSR passes through a 2-flop synchronizer.
  - An MCF rising edge on the synced value sets MIF (SR bit1).
  - A synced MAL high sets MAL_sticky.
- SR read value: {sync MCF, 0, sync MBB, MAL_sticky, 2'b00, MIF, sync RXAK}.
- SR write: writing 0 to bit1 clears MIF and writing 0 to bit4 clears MAL_sticky. Writing 1 has no effect; other bits are ignored.
- Set/clear collision: if an MCF rising edge and an MIF-clearing write land in the same cycle, the set wins.
- O_TXRX_DONE:
  - Pulses high for one cycle, one cycle after any acknowledged DR write or DR read, when CR.MEN = 1.
  - No pulse when MEN = 0.
  - Two DR accesses in consecutive cycles give two pulses separated by one low cycle; the second is delayed by one cycle.
- MEN 1->0 write: MIF and MAL_sticky clear, and any pending TXRX_DONE is dropped.
- Reset mid-access: ack and strobe are lost; registers return to reset values immediately.

Optional Feature:
- Macro: I2C_REG_IRQ_EN.
- Defined: O_IRQ = MIF & CR.MIEN, registered, one cycle behind the MIF update.
- Undefined: O_IRQ is tied to 0 and the MIEN bit is still stored/readable. MIF is still set and pollable.

Test Plan:
- Reset:
  - Assert I_RSTN low mid-access.
  - Expect outputs: ADR 0x00, FDR 0x00, CR 0x00, DR 0x00, DFSRR 0x10, ACK 0, TXRX_DONE 0, IRQ 0.
  - Expect an SR read returning 0x00 with I_I2CSR = 0.
- Register write/read:
  - Write 0xA5 to each of indexes 0, 1, 4, 5; write CR = 0xC4.
  - Expect readback 0xA5, CR reading 0xC0, RSTA high on O_I2CCR for exactly 1 cycle, and ack exactly 1 cycle after each SEL.
- TXRX_DONE strobe:
  - With CR = 0x80, write DR = 0x3C: expect one O_TXRX_DONE pulse, 2 cycles after SEL, and O_I2CDR = 0x3C.
  - Repeat with CR = 0x00: expect no pulse.
- MIF and interrupt:
  - Raise I_I2CSR bit7: expect MIF set 3 cycles later and SR reading 0x82.
  - With MIEN = 1 and the macro defined, expect O_IRQ = 1.
  - Write SR = 0x00: expect MIF = 0 and O_IRQ = 0.
- Collision:
  - Schedule an MIF-clear write in the same cycle as a synced MCF rise.
  - Expect MIF = 1 afterwards.
- Unmapped and status bits:
  - Write 0xFF to index 6, then read it: expect 0x00 with ack.
  - Pulse I_I2CSR bit4 high then low: expect SR bit4 to stay 1 until a 0 is written to it.
